// File: rtl/edge_timestamp_fifo_pkg.sv
// rtl/edge_timestamp_fifo_pkg.sv - shared types for the edge timestamp FIFO
package edge_ts_pkg;

  localparam int CNT_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    S_PRIME,
    S_RUN,
    S_OVF
  } state_t;

  typedef struct packed {
    logic                     lvl;
    logic [CNT_W_DEFAULT-1:0] ts;
  } ts_entry_t;

endpackage

// File: rtl/edge_timestamp_fifo_ts_fifo.sv
// rtl/edge_timestamp_fifo_ts_fifo.sv - synchronous FIFO, MSB-extended pointers
module ts_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign do_push = push && (!full || do_pop);
  assign fill    = wr_q - rd_q;
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_q <= rd_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/edge_timestamp_fifo.sv
// rtl/edge_timestamp_fifo.sv - captures {level, count} on each sig_in change
// EDGE_TIMESTAMP_DELTA_EN: timestamp field holds count delta since previous edge
module edge_timestamp_fifo
  import edge_ts_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sig_in,
  input  logic [CNT_W-1:0]       count_in,
  output logic                   ts_valid,
  input  logic                   ts_ready,
  output logic [CNT_W:0]         ts_data,
  output logic                   level,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fill
);

  state_t           state_q;
  logic             level_q;
  logic             edge_det;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] ts_field;

  assign edge_det = (state_q != S_PRIME) && (sig_in != level_q);
  assign drop     = edge_det && fifo_full && !ts_ready;

`ifdef EDGE_TIMESTAMP_DELTA_EN
  logic [CNT_W-1:0] prev_q;

  // Priming sample seeds the reference so the first edge reports a delta too.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else if ((state_q == S_PRIME) || edge_det) begin
      prev_q <= count_in;
    end
  end

  assign ts_field = count_in - prev_q;
`else
  assign ts_field = count_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_PRIME;
      level_q <= 1'b0;
    end else begin
      level_q <= sig_in;
      case (state_q)
        S_PRIME: state_q <= S_RUN;
        S_RUN:   if (drop) state_q <= S_OVF;
        S_OVF:   state_q <= S_OVF;
        default: state_q <= S_PRIME;
      endcase
    end
  end

  ts_fifo #(
    .W     (CNT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (edge_det),
    .pop   (ts_ready),
    .wdata ({sig_in, ts_field}),
    .rdata (ts_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  assign ts_valid = !fifo_empty;
  assign level    = level_q;
  assign overflow = (state_q == S_OVF);

endmodule

// File: tb/tb_edge_timestamp_fifo.sv
// tb/tb_edge_timestamp_fifo.sv - scoreboard bench for edge_timestamp_fifo
module tb_edge_timestamp_fifo;

  localparam int CNT_W = 10;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sig_in = 1'b0;
  logic [CNT_W-1:0]  count_in = '0;
  logic              ts_ready = 1'b0;
  logic              ts_valid;
  logic [CNT_W:0]    ts_data;
  logic              level;
  logic              overflow;
  logic [2:0]        fill;

  int n_checks = 0;
  int n_err = 0;

  logic [CNT_W:0]   exp_q[$];
  int               mdl_fill;
  bit               mdl_ovf;
  bit               primed;
  bit               mlevel;
  logic [CNT_W-1:0] mprev;

  edge_timestamp_fifo #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig_in),
    .count_in (count_in),
    .ts_valid (ts_valid),
    .ts_ready (ts_ready),
    .ts_data  (ts_data),
    .level    (level),
    .overflow (overflow),
    .fill     (fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every accepted head must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b0 && ts_valid === 1'b1 && ts_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL pop_unexpected: got %0h expected none", ts_data);
      end else begin
        chk("pop_data", int'(ts_data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset(input int cycles, input bit s);
    reset = 1'b1;
    sig_in = s;
    ts_ready = 1'b0;
    exp_q.delete();
    mdl_fill = 0;
    mdl_ovf = 0;
    primed = 0;
    mlevel = 0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_valid", int'(ts_valid), 0);
    chk("rst_data", int'(ts_data), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_fill", int'(fill), 0);
    reset = 1'b0;
  endtask

  task automatic step(input bit s, input int c, input bit r);
    logic [CNT_W-1:0] cc;
    logic [CNT_W-1:0] field;
    bit pop;
    cc = c[CNT_W-1:0];
    sig_in = s;
    count_in = cc;
    ts_ready = r;
    pop = r && (mdl_fill > 0);
    if (!primed) begin
      primed = 1;
      mprev = cc;
    end else if (s != mlevel) begin
`ifdef EDGE_TIMESTAMP_DELTA_EN
      field = cc - mprev;
`else
      field = cc;
`endif
      mprev = cc;
      if (mdl_fill < DEPTH || pop) begin
        exp_q.push_back({s, field});
        mdl_fill++;
      end else begin
        mdl_ovf = 1;
      end
    end
    mlevel = s;
    if (pop) mdl_fill--;
    @(posedge clk);
    #1;
    chk("fill", int'(fill), mdl_fill);
    chk("overflow", int'(overflow), int'(mdl_ovf));
    chk("valid", int'(ts_valid), int'(mdl_fill > 0));
    chk("level", int'(level), int'(mlevel));
  endtask

  initial begin
    int cnt;
    bit s;
    do_reset(2, 0);

    for (int c = 0; c <= 20; c++) step(0, c, 1);

    do_reset(1, 0);
    for (int c = 0; c <= 14; c++) step(c >= 5 && c < 9, c, 1);

    do_reset(1, 0);
    step(0, 0, 0);
    for (int c = 1; c <= 5; c++) step(c[0], c, 0);
    step(1, 6, 0);
    for (int c = 7; c <= 12; c++) step(1, c, 1);

    do_reset(1, 0);
    step(0, 0, 0);
    for (int c = 1; c <= 4; c++) step(c[0], c, 0);
    step(1, 5, 1);
    for (int c = 6; c <= 11; c++) step(1, c, 1);

    do_reset(1, 1);
    step(1, 0, 1);
    step(1, 1, 1);
    step(0, 7, 1);
    step(0, 8, 1);
    step(0, 9, 1);

    do_reset(1, 0);
    step(0, 0, 0);
    for (int c = 1; c <= 5; c++) step(c[0], c, 0);
    step(1, 6, 1);
    do_reset(1, 1);

    s = 0;
    cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1, s);
      end
      if ($urandom_range(0, 2) == 0) s = ~s;
      step(s, cnt, (i % 200 < 120) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      cnt++;
    end
    for (int i = 0; i < 8; i++) begin
      step(s, cnt, 1);
      cnt++;
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
